// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// opcode encodings, the legal-opcode check and the arbiter FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes 110 and 111 have no defined operation.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub wrap, bitwise and/or, and logical/arithmetic
// right shifts that take the whole B operand as the shift amount.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] C
);

    // Select the operation; undefined opcodes produce zero so nothing latches.
    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD: C = A + B;
            ALU_SUB: C = A - B;
            ALU_AND: C = A & B;
            ALU_OR:  C = A | B;
            ALU_SRL: C = A >> B;
            ALU_SRA: C = unsigned'($signed(A) >>> B);
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler letting two requesters share one ALU. An accepted
// operation is latched, executed for one cycle, and its registered result is
// held on the owner's response channel until the owner takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_prio;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    logic             w_grant1;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept0;
    logic             w_accept1;
    logic [WIDTH-1:0] w_aluC;

    // Requester 1 wins when it is alone or when both ask and it holds priority.
    // Readies are masked by reset so nothing looks accepted while held in reset.
    assign w_grant1  = req1_valid && (!req0_valid || r_prio);
    assign w_ready0  = rst_n && (r_state == IDLE) && req0_valid && !w_grant1;
    assign w_ready1  = rst_n && (r_state == IDLE) && w_grant1;
    assign w_accept0 = req0_valid && w_ready0;
    assign w_accept1 = req1_valid && w_ready1;

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;

    alu #(.WIDTH(WIDTH)) u_alu (
        .A     (r_a),
        .B     (r_b),
        .ALUOp (r_op),
        .C     (w_aluC)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and response-channel valids.
    always_comb begin
        w_nextState = r_state;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept0 || w_accept1) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                if (!r_owner) begin
                    rsp0_valid = 1'b1;
                    if (rsp0_ready) begin
                        w_nextState = IDLE;
                    end
                end else begin
                    rsp1_valid = 1'b1;
                    if (rsp1_ready) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operand capture on accept and result registration during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= ALU_ADD;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (w_accept0) begin
                r_a     <= req0_a;
                r_b     <= req0_b;
                r_op    <= req0_op;
                r_owner <= 1'b0;
                r_prio  <= 1'b1;
            end else if (w_accept1) begin
                r_a     <= req1_a;
                r_b     <= req1_b;
                r_op    <= req1_op;
                r_owner <= 1'b1;
                r_prio  <= 1'b0;
            end
            if (r_state == EXEC) begin
                if (op_legal(r_op)) begin
                    rsp_data <= w_aluC;
                    rsp_err  <= 1'b0;
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic [2:0]  req0_op = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic [2:0]  req1_op = '0;
    logic        rsp0_valid;
    logic        rsp0_ready = 1'b0;
    logic        rsp1_valid;
    logic        rsp1_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one operation from a single requester with its rsp_ready held high
    // and wait (bounded) for the response; lat counts cycles from accept.
    task automatic runOp(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output logic [31:0] data,
                         output logic err, output int lat, output logic otherSeen);
        bit got;
        data = '0;
        err = 1'b0;
        lat = -1;
        otherSeen = 1'b0;
        @(negedge clk);
        if (who == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; rsp0_ready = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; rsp1_ready = 1'b1;
        end
        #1;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if ((who == 0 && rsp1_valid) || (who == 1 && rsp0_valid)) otherSeen = 1'b1;
            if ((who == 0) ? rsp0_valid : rsp1_valid) begin
                data = rsp_data;
                err = rsp_err;
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_SUB; req0_valid = 1'b1;
        req1_a = 32'd1; req1_b = 32'd2; req1_op = OP_ADD; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err} !== 6'b0) begin
            errs++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err});
        end
        vecs++;
        if (rsp_data !== 32'h0) begin
            errs++;
            $display("[TB] FAIL reset_data: got %h want 00000000", rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (req0_ready !== 1'b1) begin
            errs++;
            $display("[TB] FAIL release_req0_ready: got %b want 1", req0_ready);
        end
        vecs++;
        if (req1_ready !== 1'b0) begin
            errs++;
            $display("[TB] FAIL release_req1_ready: got %b want 0", req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single_req1();
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        oth;
        runOp(1, 32'hFFFF_FFFF, 32'h1, OP_ADD, d, e, lat, oth);
        vecs++;
        if (lat !== 2) begin
            errs++;
            $display("[TB] FAIL single_latency: got %0d want 2", lat);
        end
        vecs++;
        if (d !== 32'h0) begin
            errs++;
            $display("[TB] FAIL single_data: got %h want 00000000", d);
        end
        vecs++;
        if (e !== 1'b0) begin
            errs++;
            $display("[TB] FAIL single_err: got %b want 0", e);
        end
        vecs++;
        if (oth !== 1'b0) begin
            errs++;
            $display("[TB] FAIL single_rsp0_quiet: got %b want 0", oth);
        end
        @(negedge clk);
        #1;
        vecs++;
        if ({busy, rsp1_valid} !== 2'b00) begin
            errs++;
            $display("[TB] FAIL single_back_idle: got %b want 00", {busy, rsp1_valid});
        end
    endtask

    task automatic test_back_to_back();
        int          gCyc[4];
        int          gOwn[4];
        logic [31:0] rData[4];
        int          rOwn[4];
        int          nG;
        int          nR;
        for (int i = 0; i < 4; i++) begin
            gCyc[i] = -100; gOwn[i] = -1; rData[i] = 32'hDEAD_BEEF; rOwn[i] = -1;
        end
        nG = 0;
        nR = 0;
        @(negedge clk);
        req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_SUB; req0_valid = 1'b1;
        req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = OP_SRA; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if ((req0_ready || req1_ready) && nG < 4) begin
                gCyc[nG] = c;
                gOwn[nG] = req1_ready ? 1 : 0;
                nG++;
            end
            if ((rsp0_valid || rsp1_valid) && nR < 4) begin
                rData[nR] = rsp_data;
                rOwn[nR] = rsp1_valid ? 1 : 0;
                nR++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vecs++;
        if (nG !== 4 || nR !== 4) begin
            errs++;
            $display("[TB] FAIL b2b_counts: got grants=%0d responses=%0d want 4/4", nG, nR);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (gOwn[i] !== (i % 2)) begin
                errs++;
                $display("[TB] FAIL b2b_grant%0d: got owner %0d want %0d", i, gOwn[i], i % 2);
            end
            vecs++;
            if (rOwn[i] !== (i % 2) || rData[i] !== ((i % 2) ? 32'hF800_0000 : 32'hFFFF_FFFE)) begin
                errs++;
                $display("[TB] FAIL b2b_rsp%0d: got owner %0d data %h want owner %0d data %h",
                         i, rOwn[i], rData[i], i % 2,
                         (i % 2) ? 32'hF800_0000 : 32'hFFFF_FFFE);
            end
            if (i > 0) begin
                vecs++;
                if (gCyc[i] - gCyc[i-1] !== 3) begin
                    errs++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d want 3", i, gCyc[i] - gCyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        oth;
        runOp(0, 32'h1234_5678, 32'h1, 3'b111, d, e, lat, oth);
        vecs++;
        if (lat !== 2 || e !== 1'b1 || d !== 32'h0) begin
            errs++;
            $display("[TB] FAIL illegal_111: got lat=%0d err=%b data=%h want 2/1/00000000", lat, e, d);
        end
        runOp(0, 32'h0000_00F0, 32'h0000_000F, OP_OR, d, e, lat, oth);
        vecs++;
        if (lat !== 2 || e !== 1'b0 || d !== 32'h0000_00FF) begin
            errs++;
            $display("[TB] FAIL legal_after_illegal: got lat=%0d err=%b data=%h want 2/0/000000ff", lat, e, d);
        end
        runOp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, d, e, lat, oth);
        vecs++;
        if (lat !== 2 || e !== 1'b1 || d !== 32'h0) begin
            errs++;
            $display("[TB] FAIL illegal_110: got lat=%0d err=%b data=%h want 2/1/00000000", lat, e, d);
        end
    endtask

    task automatic test_shift_and_logic();
        logic [31:0] ta[5] = '{32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h0000_F0F0, 32'h4000_0000};
        logic [31:0] tb[5] = '{32'd32,        32'd40,        32'd4,         32'h0000_FF00, 32'd40};
        logic [2:0]  top[5] = '{OP_SRL,       OP_SRA,        OP_SRL,        OP_AND,        OP_SRA};
        logic [31:0] tExp[5] = '{32'h0,       32'hFFFF_FFFF, 32'h0800_0000, 32'h0000_F000, 32'h0};
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        oth;
        for (int i = 0; i < 5; i++) begin
            runOp(i % 2, ta[i], tb[i], top[i], d, e, lat, oth);
            vecs++;
            if (lat !== 2 || e !== 1'b0 || d !== tExp[i]) begin
                errs++;
                $display("[TB] FAIL shift_vec%0d: got lat=%0d err=%b data=%h want 2/0/%h",
                         i, lat, e, d, tExp[i]);
            end
        end
    endtask

    task automatic test_stall_and_reset();
        @(negedge clk);
        req0_a = 32'd3; req0_b = 32'd4; req0_op = OP_ADD; req0_valid = 1'b1;
        rsp0_ready = 1'b0;
        #1;
        vecs++;
        if (req0_ready !== 1'b1) begin
            errs++;
            $display("[TB] FAIL stall_accept: got %b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 32'd1; req1_b = 32'd1; req1_op = OP_ADD; req1_valid = 1'b1;
        #1;
        vecs++;
        if ({busy, req1_ready, rsp0_valid} !== 3'b100) begin
            errs++;
            $display("[TB] FAIL stall_exec: got %b want 100", {busy, req1_ready, rsp0_valid});
        end
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            #1;
            vecs++;
            if ({rsp0_valid, rsp1_valid, req1_ready, rsp_err, rsp_data} !== {4'b1000, 32'd7}) begin
                errs++;
                $display("[TB] FAIL stall_hold%0d: got v0=%b v1=%b r1=%b err=%b data=%h want 1/0/0/0/00000007",
                         c, rsp0_valid, rsp1_valid, req1_ready, rsp_err, rsp_data);
            end
        end
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_data} !== 38'h0) begin
            errs++;
            $display("[TB] FAIL midstall_reset: got rdy=%b%b v=%b%b busy=%b err=%b data=%h want all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errs++;
            $display("[TB] FAIL post_reset_grant: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            vecs++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                errs++;
                $display("[TB] FAIL no_stale_rsp%0d: got %b want 000", c, {rsp0_valid, rsp1_valid, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_req1();
        test_back_to_back();
        test_illegal();
        test_shift_and_logic();
        test_stall_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
